prescaled_updown_counter: RTL and testbench

Parametrised successor to the board-level 8-bit tick counter.
- Prescaled up/down counter with WIDTH-bit count and programmable modulus.
- Wrap or saturate mode; synchronous preset load; one-cycle terminal-count pulse.
- Sits between board buttons/switches and LED/7-seg display logic, and reuses one clock domain.

---
 rtl/counter_pkg.sv | 40 ++++
 rtl/tick_prescaler.sv | 48 ++++
 rtl/prescaled_updown_counter.sv | 175 +++++++++++++++++
 tb/tb_prescaled_updown_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//
// Shared constants, types and helpers for prescaled_updown_counter and its
// tick_prescaler sub-block.
//
//   DIR_UP / DIR_DOWN     : encoding of the up_down input
//   MODE_WRAP / MODE_SAT  : encoding of the sat_mode input
//   count_act_e           : action the count register takes on a clock edge
//   clog2()               : prescaler register width, never less than 1 bit
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // What the count register does on the next edge, after priority decode.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DOWN = 2'd3
    } count_act_e;

    // Bits needed to hold 0..value-1; a divider of 1 still needs one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned w;
        w = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
//
// Free-running divide-by-TICK_DIV phase counter that only advances while
// enabled. step_en is combinational and is high during the last enabled
// cycle of each period; the phase counter then returns to 0.
//
// Parameters:
//   TICK_DIV    : clk cycles per step (>= 1)
// Ports:
//   clk         : system clock
//   reset_btn_n : asynchronous active-low reset
//   enable      : 1 = advance, 0 = hold phase
//   step_en     : (phase == TICK_DIV-1) && enable
// ----------------------------------------------------------------------------
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic reset_btn_n,
    input  logic enable,
    output logic step_en
);

    localparam int unsigned   PW   = clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_phase;
    logic          w_at_last;

    assign w_at_last = (r_phase == LAST);
    assign step_en   = w_at_last && enable;

    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            r_phase <= '0;
        end else if (enable) begin
            if (w_at_last) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// ----------------------------------------------------------------------------
// prescaled_updown_counter
//
// WIDTH-bit up/down counter stepping once every TICK_DIV enabled clocks,
// counting over 0..MAX_VALUE with wrap or saturate behaviour at the bounds,
// a synchronous clamped preset load and a one-cycle terminal-count pulse.
//
// Build option:
//   BTN_SYNC_EN  defined   -> preset_btn, up_down and sat_mode pass through
//                             2-flop synchronisers (2 cycles extra latency)
//                undefined -> those inputs are used directly and must be
//                             synchronous to clk
//
// Parameters:
//   WIDTH       : count width in bits (2..32)
//   TICK_DIV    : clk cycles per count step (>= 1)
//   MAX_VALUE   : highest legal count (<= 2**WIDTH-1)
// Ports:
//   clk         : system clock
//   reset_btn_n : asynchronous active-low reset
//   enable      : 1 = prescaler runs and count steps; 0 = both hold
//   up_down     : 1 = count up, 0 = count down
//   sat_mode    : 0 = wrap at bounds, 1 = saturate at bounds
//   preset_btn  : level-sensitive synchronous load request
//   load_value  : value loaded on preset (clamped to MAX_VALUE)
//   count       : current count (registered)
//   tick        : registered one-cycle pulse per prescaler rollover
//   tc          : registered one-cycle terminal-count pulse
// ----------------------------------------------------------------------------
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     TICK_DIV  = 100000000,
    parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             reset_btn_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             preset_btn,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

    logic             w_step_en;
    logic             w_preset;
    logic             w_up_down;
    logic             w_sat_mode;
    logic [WIDTH-1:0] w_load_clamped;
    count_act_e       w_act;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;

    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_tc;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk         (clk),
        .reset_btn_n (reset_btn_n),
        .enable      (enable),
        .step_en     (w_step_en)
    );

    // ------------------------------------------------------------------
    // Control input conditioning
    // ------------------------------------------------------------------
`ifdef BTN_SYNC_EN
    logic [1:0] r_preset_sync;
    logic [1:0] r_dir_sync;
    logic [1:0] r_mode_sync;

    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            r_preset_sync <= '0;
            r_dir_sync    <= '0;
            r_mode_sync   <= '0;
        end else begin
            r_preset_sync <= {r_preset_sync[0], preset_btn};
            r_dir_sync    <= {r_dir_sync[0],    up_down};
            r_mode_sync   <= {r_mode_sync[0],   sat_mode};
        end
    end

    assign w_preset   = r_preset_sync[1];
    assign w_up_down  = r_dir_sync[1];
    assign w_sat_mode = r_mode_sync[1];
`else
    assign w_preset   = preset_btn;
    assign w_up_down  = up_down;
    assign w_sat_mode = sat_mode;
`endif

    // Out-of-range preset values saturate to the top of the modulus.
    assign w_load_clamped = (load_value > MAX_CNT) ? MAX_CNT : load_value;

    // ------------------------------------------------------------------
    // Action decode: preset beats a step, a step beats hold.
    // ------------------------------------------------------------------
    always_comb begin
        w_act = ACT_HOLD;
        if (w_preset) begin
            w_act = ACT_LOAD;
        end else if (w_step_en) begin
            w_act = (w_up_down == DIR_UP) ? ACT_UP : ACT_DOWN;
        end
    end

    // ------------------------------------------------------------------
    // Next count / terminal count
    // ------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        unique case (w_act)
            ACT_LOAD: begin
                w_count_nxt = w_load_clamped;
            end
            ACT_UP: begin
                if (r_count == MAX_CNT) begin
                    w_tc_nxt = 1'b1;
                    if (w_sat_mode == MODE_WRAP) begin
                        w_count_nxt = '0;
                    end
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end
            ACT_DOWN: begin
                if (r_count == '0) begin
                    w_tc_nxt = 1'b1;
                    if (w_sat_mode == MODE_WRAP) begin
                        w_count_nxt = MAX_CNT;
                    end
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tick  <= w_step_en;
            r_tc    <= w_tc_nxt;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign tc    = r_tc;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
module tb_prescaled_updown_counter;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset_btn_n;
    logic       enable;
    logic       up_down;
    logic       sat_mode;
    logic       preset_btn;
    logic [7:0] load_value;

    logic [7:0] count_a, count_b;
    logic [3:0] count_c;
    logic       tick_a, tick_b, tick_c;
    logic       tc_a, tc_b, tc_c;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    // A: small modulus (0..9), B: modulus 0..200 for clamping, C: divide-by-1
    prescaled_updown_counter #(.WIDTH(8), .TICK_DIV(4), .MAX_VALUE(9)) u_dut_a (
        .clk(clk), .reset_btn_n(reset_btn_n), .enable(enable), .up_down(up_down),
        .sat_mode(sat_mode), .preset_btn(preset_btn), .load_value(load_value),
        .count(count_a), .tick(tick_a), .tc(tc_a));

    prescaled_updown_counter #(.WIDTH(8), .TICK_DIV(4), .MAX_VALUE(200)) u_dut_b (
        .clk(clk), .reset_btn_n(reset_btn_n), .enable(enable), .up_down(up_down),
        .sat_mode(sat_mode), .preset_btn(preset_btn), .load_value(load_value),
        .count(count_b), .tick(tick_b), .tc(tc_b));

    prescaled_updown_counter #(.WIDTH(4), .TICK_DIV(1)) u_dut_c (
        .clk(clk), .reset_btn_n(reset_btn_n), .enable(enable), .up_down(up_down),
        .sat_mode(sat_mode), .preset_btn(preset_btn), .load_value(load_value[3:0]),
        .count(count_c), .tick(tick_c), .tc(tc_c));

    // Reference model: phase counted modulo the divider, count as integers.
    int unsigned m_div  [N] = '{4, 4, 1};
    int unsigned m_max  [N] = '{9, 200, 15};
    int unsigned m_mask [N] = '{255, 255, 15};
    int unsigned m_ps   [N];
    int unsigned m_cnt  [N];
    bit          m_tick [N];
    bit          m_tc   [N];
    bit          sp1, sp2, su1, su2, ss1, ss2;

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_ps[d] = 0; m_cnt[d] = 0; m_tick[d] = 0; m_tc[d] = 0;
        end
        sp1 = 0; sp2 = 0; su1 = 0; su2 = 0; ss1 = 0; ss2 = 0;
    endtask

    task automatic model_clock();
        bit p, u, s, step;
        int unsigned ld;
`ifdef BTN_SYNC_EN
        p = sp2; u = su2; s = ss2;
        sp2 = sp1; su2 = su1; ss2 = ss1;
        sp1 = preset_btn; su1 = up_down; ss1 = sat_mode;
`else
        p = preset_btn; u = up_down; s = sat_mode;
`endif
        for (int d = 0; d < N; d++) begin
            step = enable && (m_ps[d] == m_div[d] - 1);
            if (enable) m_ps[d] = (m_ps[d] + 1) % m_div[d];
            m_tick[d] = step;
            m_tc[d]   = 0;
            if (p) begin
                ld = 32'(load_value) & m_mask[d];
                m_cnt[d] = (ld > m_max[d]) ? m_max[d] : ld;
            end else if (step) begin
                if (u) begin
                    if (m_cnt[d] == m_max[d]) begin
                        m_tc[d] = 1;
                        if (!s) m_cnt[d] = 0;
                    end else m_cnt[d] = m_cnt[d] + 1;
                end else begin
                    if (m_cnt[d] == 0) begin
                        m_tc[d] = 1;
                        if (!s) m_cnt[d] = m_max[d];
                    end else m_cnt[d] = m_cnt[d] - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count_a", 32'(count_a), m_cnt[0]);
        chk("tick_a",  32'(tick_a),  32'(m_tick[0]));
        chk("tc_a",    32'(tc_a),    32'(m_tc[0]));
        chk("count_b", 32'(count_b), m_cnt[1]);
        chk("tick_b",  32'(tick_b),  32'(m_tick[1]));
        chk("tc_b",    32'(tc_b),    32'(m_tc[1]));
        chk("count_c", 32'(count_c), m_cnt[2]);
        chk("tick_c",  32'(tick_c),  32'(m_tick[2]));
        chk("tc_c",    32'(tc_c),    32'(m_tc[2]));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_btn_n) model_reset();
        else model_clock();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        reset_btn_n = 1'b0; enable = 1'b0; up_down = 1'b1; sat_mode = 1'b0;
        preset_btn = 1'b0; load_value = 8'h00;
        model_reset();

        // Reset state
        run(3);
        reset_btn_n = 1'b1;

        // Up, wrap, steady tick cadence; A wraps 9->0 within the run
        enable = 1'b1;
        run(60);

        // Down from 0 wraps to MAX
        preset_btn = 1'b1; load_value = 8'd0; run(1);
        preset_btn = 1'b0; up_down = 1'b0;
        run(16);

        // Saturate up at MAX (A: 9; B/C loaded to 9)
        preset_btn = 1'b1; load_value = 8'd9; run(1);
        preset_btn = 1'b0; up_down = 1'b1; sat_mode = 1'b1;
        run(16);
        // Saturate down at 0
        preset_btn = 1'b1; load_value = 8'd0; run(1);
        preset_btn = 1'b0; up_down = 1'b0;
        run(16);
        sat_mode = 1'b0;

        // Preset: exact, clamped, and held across step_en edges
        preset_btn = 1'b1; load_value = 8'hC8; run(1);
        preset_btn = 1'b0; run(3);
        preset_btn = 1'b1; load_value = 8'hFF; run(1);
        preset_btn = 1'b0; run(3);
        preset_btn = 1'b1; load_value = 8'd7; run(12);
        preset_btn = 1'b0; up_down = 1'b1; run(8);

        // Enable pause mid-period
        run(2);
        enable = 1'b0; run(10);
        enable = 1'b1; run(8);

        // Asynchronous reset between edges with count non-zero
        preset_btn = 1'b1; load_value = 8'd5; run(1);
        preset_btn = 1'b0; run(3);
        #2;
        reset_btn_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count_a", 32'(count_a), 32'd0);
        chk("async_rst_count_b", 32'(count_b), 32'd0);
        chk("async_rst_tick_a",  32'(tick_a),  32'd0);
        chk("async_rst_tc_a",    32'(tc_a),    32'd0);
        run(2);
        reset_btn_n = 1'b1;
        run(10);

        // Preset pulse latency (model tracks the synchroniser delay if built in)
        preset_btn = 1'b1; load_value = 8'd3; run(1);
        preset_btn = 1'b0; run(5);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            up_down    = ($urandom_range(0, 3) != 0) ? up_down : ~up_down;
            sat_mode   = ($urandom_range(0, 15) != 0) ? sat_mode : ~sat_mode;
            preset_btn = ($urandom_range(0, 24) == 0);
            load_value = 8'($urandom_range(0, 255));
            run(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
